// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores on a local word-wide
// data memory with optional wait states, registered into the MEM/WB boundary.
//
// Handshake: the EX/MEM register presents an operation every cycle. An access
// (load or store) is accepted on the rising edge where Stall is low; while
// Stall is high the upstream stage must hold its inputs unchanged, and each
// such edge loads a bubble into MEM/WB. Non-memory ops never see Stall high.
module mem_access_stage #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] ReadData2In,
    input  logic [1:0]  MemWriteIn,
    input  logic [1:0]  MemReadIn,
    input  logic        LoadUnsignedIn,
    input  logic        MemToRegIn,
    input  logic        RegWriteIn,
    input  logic [31:0] WriteRegisterIn,
    output logic        Stall,
    output logic        AlignFault,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [31:0] WriteRegisterOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic [0:0]  DebugState
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    byte_lane;
    logic          is_store;
    logic          is_load;
    logic          access;
    logic [1:0]    size;
    logic          misaligned;
    logic          complete;
    logic [31:0]   mem_word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_value;

    // Upper address bits above the array size are ignored, so addresses wrap.
    assign word_idx  = ALUResultIn[AW+1:2];
    assign byte_lane = ALUResultIn[1:0];

    // A store wins when both store and load codes are present.
    assign is_store = (MemWriteIn != 2'b00);
    assign is_load  = !is_store && (MemReadIn != 2'b00);
    assign access   = is_store || is_load;
    assign size     = is_store ? MemWriteIn : MemReadIn;

    assign DebugState = state;
    assign complete   = !Stall;

    // Word accesses need addr[1:0]==0, half accesses need addr[0]==0.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = (byte_lane != 2'b00);
            2'b10:   misaligned = byte_lane[0];
            default: misaligned = 1'b0;
        endcase
    end

    // Stall holds off upstream for every cycle of an access except the last.
    always_comb begin
        Stall = 1'b0;
        if (WAIT_CYCLES != 0) begin
            if (state == IDLE) Stall = access;
            else               Stall = (cnt != '0);
        end
    end

    // Lane selection and sign/zero extension of the word read this cycle.
    always_comb begin
        mem_word   = mem[word_idx];
        half_sel   = byte_lane[1] ? mem_word[31:16] : mem_word[15:0];
        byte_sel   = mem_word[{byte_lane, 3'b000} +: 8];
        load_value = '0;
        case (MemReadIn)
            2'b01:   load_value = mem_word;
            2'b10:   load_value = LoadUnsignedIn ? {16'h0000, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
            2'b11:   load_value = LoadUnsignedIn ? {24'h000000, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
            default: load_value = '0;
        endcase
    end

    // Wait-state FSM: IDLE counts the first access cycle, BUSY the rest.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && (WAIT_CYCLES != 0)) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (cnt != '0) cnt   <= cnt - CW'(1);
                    else           state <= IDLE;
                end
            endcase
        end
    end

    // Store commit on the completion edge; misaligned stores are dropped.
    always_ff @(posedge Clock) begin
        if (complete && is_store && !misaligned) begin
            case (MemWriteIn)
                2'b01:   mem[word_idx] <= ReadData2In;
                2'b10:   mem[word_idx][{byte_lane[1], 4'b0000} +: 16] <= ReadData2In[15:0];
                2'b11:   mem[word_idx][{byte_lane, 3'b000} +: 8] <= ReadData2In[7:0];
                default: ;
            endcase
        end
    end

    // MEM/WB register: bubble on stalled edges, capture on completion edges.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            AlignFault       <= 1'b0;
            ReadDataOut      <= '0;
            ALUResultOut     <= '0;
            WriteRegisterOut <= '0;
            RegWriteOut      <= 1'b0;
            MemToRegOut      <= 1'b0;
        end else if (Stall) begin
            AlignFault       <= 1'b0;
            ReadDataOut      <= '0;
            ALUResultOut     <= '0;
            WriteRegisterOut <= '0;
            RegWriteOut      <= 1'b0;
            MemToRegOut      <= 1'b0;
        end else begin
            AlignFault       <= access && misaligned;
            ReadDataOut      <= (is_load && !misaligned) ? load_value : '0;
            ALUResultOut     <= ALUResultIn;
            WriteRegisterOut <= WriteRegisterIn;
            RegWriteOut      <= RegWriteIn;
            MemToRegOut      <= MemToRegIn;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (0, 2 and 3 wait states) share
// one set of inputs; each test drives the shared inputs and checks only the
// instance it is pacing.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_in;
    logic [31:0] rd2_in;
    logic [1:0]  mw_in;
    logic [1:0]  mr_in;
    logic        lu_in;
    logic        m2r_in;
    logic        rw_in;
    logic [31:0] wreg_in;

    logic        stall_o [3];
    logic        fault_o [3];
    logic [31:0] rdata_o [3];
    logic [31:0] alu_o   [3];
    logic [31:0] wreg_o  [3];
    logic        rw_o    [3];
    logic        m2r_o   [3];
    logic [0:0]  state_o [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mw;
        logic [1:0]  mr;
        logic        lu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    vec_t vq[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .Clock(clk), .Reset(rst), .ALUResultIn(alu_in), .ReadData2In(rd2_in),
        .MemWriteIn(mw_in), .MemReadIn(mr_in), .LoadUnsignedIn(lu_in),
        .MemToRegIn(m2r_in), .RegWriteIn(rw_in), .WriteRegisterIn(wreg_in),
        .Stall(stall_o[0]), .AlignFault(fault_o[0]), .ReadDataOut(rdata_o[0]),
        .ALUResultOut(alu_o[0]), .WriteRegisterOut(wreg_o[0]),
        .RegWriteOut(rw_o[0]), .MemToRegOut(m2r_o[0]), .DebugState(state_o[0]));

    mem_access_stage #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .Clock(clk), .Reset(rst), .ALUResultIn(alu_in), .ReadData2In(rd2_in),
        .MemWriteIn(mw_in), .MemReadIn(mr_in), .LoadUnsignedIn(lu_in),
        .MemToRegIn(m2r_in), .RegWriteIn(rw_in), .WriteRegisterIn(wreg_in),
        .Stall(stall_o[1]), .AlignFault(fault_o[1]), .ReadDataOut(rdata_o[1]),
        .ALUResultOut(alu_o[1]), .WriteRegisterOut(wreg_o[1]),
        .RegWriteOut(rw_o[1]), .MemToRegOut(m2r_o[1]), .DebugState(state_o[1]));

    mem_access_stage #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .Clock(clk), .Reset(rst), .ALUResultIn(alu_in), .ReadData2In(rd2_in),
        .MemWriteIn(mw_in), .MemReadIn(mr_in), .LoadUnsignedIn(lu_in),
        .MemToRegIn(m2r_in), .RegWriteIn(rw_in), .WriteRegisterIn(wreg_in),
        .Stall(stall_o[2]), .AlignFault(fault_o[2]), .ReadDataOut(rdata_o[2]),
        .ALUResultOut(alu_o[2]), .WriteRegisterOut(wreg_o[2]),
        .RegWriteOut(rw_o[2]), .MemToRegOut(m2r_o[2]), .DebugState(state_o[2]));

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] mw, input logic [1:0] mr, input logic lu,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rw, input logic m2r, input logic [31:0] wreg);
        mw_in   = mw;
        mr_in   = mr;
        lu_in   = lu;
        alu_in  = addr;
        rd2_in  = wdata;
        rw_in   = rw;
        m2r_in  = m2r;
        wreg_in = wreg;
    endtask

    task automatic drive_idle();
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Present an op at the next falling edge and hold it until instance k
    // completes; returns just after the completion edge with the number of
    // stalled cycles seen.
    task automatic issue(input int k, input logic [1:0] mw, input logic [1:0] mr,
                         input logic lu, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rw, input logic m2r, input logic [31:0] wreg,
                         output int stalls);
        logic s;
        stalls = 0;
        @(negedge clk);
        drive(mw, mr, lu, addr, wdata, rw, m2r, wreg);
        forever begin
            #1 s = stall_o[k];
            @(posedge clk);
            #1;
            if (!s) break;
            stalls++;
            if (stalls > 16) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: inst %0d still stalled after %0d cycles", k, stalls);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void add(input logic [1:0] mw, input logic [1:0] mr, input logic lu,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_fault);
        vq.push_back('{mw, mr, lu, addr, wdata, exp_rd, exp_fault});
    endfunction

    initial begin
        int st;
        logic rwv;
        logic m2rv;

        rst = 1'b1;
        drive_idle();

        // Vectors for the zero-wait instance, applied back to back.
        add(2'b01, 2'b00, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
        add(2'b00, 2'b01, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
        add(2'b11, 2'b00, 1'b0, 32'h13,   32'hAAAAAA80, 32'h0,        1'b0);
        add(2'b00, 2'b11, 1'b0, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0);
        add(2'b00, 2'b11, 1'b1, 32'h13,   32'h0,        32'h00000080, 1'b0);
        add(2'b00, 2'b01, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0);
        add(2'b00, 2'b11, 1'b0, 32'h12,   32'h0,        32'hFFFFFFAD, 1'b0);
        add(2'b00, 2'b10, 1'b1, 32'h10,   32'h0,        32'h0000BEEF, 1'b0);
        add(2'b00, 2'b10, 1'b0, 32'h12,   32'h0,        32'hFFFF80AD, 1'b0);
        add(2'b01, 2'b00, 1'b0, 32'h20,   32'h0,        32'h0,        1'b0);
        add(2'b10, 2'b00, 1'b0, 32'h22,   32'h55558001, 32'h0,        1'b0);
        add(2'b00, 2'b10, 1'b0, 32'h22,   32'h0,        32'hFFFF8001, 1'b0);
        add(2'b00, 2'b10, 1'b1, 32'h22,   32'h0,        32'h00008001, 1'b0);
        add(2'b00, 2'b10, 1'b0, 32'h21,   32'h0,        32'h0,        1'b1);
        add(2'b00, 2'b01, 1'b1, 32'h20,   32'h0,        32'h80010000, 1'b0);
        add(2'b01, 2'b00, 1'b0, 32'h40,   32'h01020304, 32'h0,        1'b0);
        add(2'b01, 2'b00, 1'b0, 32'h41,   32'hFFFFFFFF, 32'h0,        1'b1);
        add(2'b10, 2'b00, 1'b0, 32'h43,   32'hFFFFFFFF, 32'h0,        1'b1);
        add(2'b00, 2'b01, 1'b0, 32'h40,   32'h0,        32'h01020304, 1'b0);
        add(2'b01, 2'b01, 1'b0, 32'h50,   32'h11223344, 32'h0,        1'b0);
        add(2'b00, 2'b01, 1'b0, 32'h50,   32'h0,        32'h11223344, 1'b0);
        add(2'b00, 2'b00, 1'b0, 32'hCAFEF00D, 32'h12345678, 32'h0,   1'b0);
        add(2'b01, 2'b00, 1'b0, 32'h1000, 32'h5A5AA5A5, 32'h0,        1'b0);
        add(2'b00, 2'b01, 1'b0, 32'h0,    32'h0,        32'h5A5AA5A5, 1'b0);
        add(2'b00, 2'b11, 1'b1, 32'h1003, 32'h0,        32'h0000005A, 1'b0);
        add(2'b00, 2'b01, 1'b1, 32'h2,    32'h0,        32'h0,        1'b1);

        // Reset state of every instance.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check32($sformatf("rst%0d_stall", k), 32'(stall_o[k]), 32'h0);
            check32($sformatf("rst%0d_fault", k), 32'(fault_o[k]), 32'h0);
            check32($sformatf("rst%0d_rd", k),    rdata_o[k],      32'h0);
            check32($sformatf("rst%0d_alu", k),   alu_o[k],        32'h0);
            check32($sformatf("rst%0d_wreg", k),  wreg_o[k],       32'h0);
            check32($sformatf("rst%0d_rw", k),    32'(rw_o[k]),    32'h0);
            check32($sformatf("rst%0d_m2r", k),   32'(m2r_o[k]),   32'h0);
            check32($sformatf("rst%0d_state", k), 32'(state_o[k]), 32'h0);
        end
        rst = 1'b0;

        // Table-driven run on the zero-wait instance.
        for (int i = 0; i < vq.size(); i++) begin
            rwv  = (i % 2) == 1;
            m2rv = (i % 4) >= 2;
            issue(0, vq[i].mw, vq[i].mr, vq[i].lu, vq[i].addr, vq[i].wdata,
                  rwv, m2rv, 32'(i + 1), st);
            check32($sformatf("vec%0d_stalls", i), 32'(st),          32'h0);
            check32($sformatf("vec%0d_rd", i),     rdata_o[0],       vq[i].exp_rd);
            check32($sformatf("vec%0d_fault", i),  32'(fault_o[0]),  32'(vq[i].exp_fault));
            check32($sformatf("vec%0d_alu", i),    alu_o[0],         vq[i].addr);
            check32($sformatf("vec%0d_wreg", i),   wreg_o[0],        32'(i + 1));
            check32($sformatf("vec%0d_rw", i),     32'(rw_o[0]),     32'(rwv));
            check32($sformatf("vec%0d_m2r", i),    32'(m2r_o[0]),    32'(m2rv));
        end

        // Two wait states: held load stalls twice with two bubbles.
        do_reset();
        issue(1, 2'b01, 2'b00, 1'b0, 32'h60, 32'h77665544, 1'b0, 1'b0, 32'h0, st);
        check32("w2_store_stalls", 32'(st), 32'h2);
        @(negedge clk);
        drive(2'b00, 2'b01, 1'b0, 32'h60, 32'h0, 1'b1, 1'b1, 32'h7);
        for (int c = 0; c < 3; c++) begin
            #1 check32($sformatf("w2_stall_c%0d", c), 32'(stall_o[1]), 32'(c < 2));
            @(posedge clk);
            #1;
            check32($sformatf("w2_rw_c%0d", c),  32'(rw_o[1]),  32'(c == 2));
            check32($sformatf("w2_m2r_c%0d", c), 32'(m2r_o[1]), 32'(c == 2));
            if (c < 2) @(negedge clk);
        end
        check32("w2_load_data", rdata_o[1], 32'h77665544);
        check32("w2_load_wreg", wreg_o[1], 32'h7);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0, 32'h0BADC0DE, 32'h0, 1'b1, 1'b0, 32'h9);
        #1 check32("w2_alu_op_stall", 32'(stall_o[1]), 32'h0);
        @(posedge clk);
        #1;
        check32("w2_alu_op_result", alu_o[1], 32'h0BADC0DE);
        check32("w2_alu_op_rw", 32'(rw_o[1]), 32'h1);
        check32("w2_alu_op_rd", rdata_o[1], 32'h0);

        // Three wait states: reset in the second BUSY cycle aborts a store.
        do_reset();
        issue(2, 2'b01, 2'b00, 1'b0, 32'h40, 32'h11111111, 1'b0, 1'b0, 32'h0, st);
        check32("w3_first_store_stalls", 32'(st), 32'h3);
        @(negedge clk);
        drive(2'b01, 2'b00, 1'b0, 32'h40, 32'h22222222, 1'b0, 1'b0, 32'h0);
        #1 check32("w3_abort_stall0", 32'(stall_o[2]), 32'h1);
        @(posedge clk);
        #1 check32("w3_abort_busy", 32'(state_o[2]), 32'h1);
        @(negedge clk);
        #1 check32("w3_abort_stall1", 32'(stall_o[2]), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check32("w3_abort_state", 32'(state_o[2]), 32'h0);
        check32("w3_abort_stall", 32'(stall_o[2]), 32'h0);
        check32("w3_abort_rd",    rdata_o[2],      32'h0);
        check32("w3_abort_rw",    32'(rw_o[2]),    32'h0);
        check32("w3_abort_fault", 32'(fault_o[2]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(2, 2'b00, 2'b01, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h3, st);
        check32("w3_reload_stalls", 32'(st), 32'h3);
        check32("w3_reload_data", rdata_o[2], 32'h11111111);

        // Misaligned access with wait states still faults on completion.
        issue(2, 2'b00, 2'b01, 1'b0, 32'h42, 32'h0, 1'b1, 1'b0, 32'h4, st);
        check32("w3_misaligned_fault", 32'(fault_o[2]), 32'h1);
        check32("w3_misaligned_rd", rdata_o[2], 32'h0);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1 check32("w3_fault_pulse_end", 32'(fault_o[2]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
